// File: rtl/meta_array_ctrl.sv
// Front-end controller for the per-way metadata SRAM array: sweeps every set to INIT_VAL after
// reset or flush, then serves one read and one write per cycle with same-cycle write-to-read forwarding.
module meta_array_ctrl #(
    parameter int              SETS     = 512,
    parameter int              ADDR_W   = 9,
    parameter int              WAYS     = 4,
    parameter int              DATA_W   = 2,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    output logic                     init_done,
    input  logic                     rd_valid,
    output logic                     rd_ready,
    input  logic [ADDR_W-1:0]        rd_set,
    output logic                     resp_valid,
    output logic [WAYS*DATA_W-1:0]   resp_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        wr_set,
    input  logic [WAYS-1:0]          wr_maskOH,
    input  logic [WAYS*DATA_W-1:0]   wr_data,
    output logic [ADDR_W-1:0]        arr_r_addr,
    input  logic [WAYS*DATA_W-1:0]   arr_r_data,
    output logic                     arr_w_en,
    output logic [ADDR_W-1:0]        arr_w_addr,
    output logic [WAYS*DATA_W-1:0]   arr_w_data,
    output logic [WAYS-1:0]          arr_w_maskOH
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_SET = ADDR_W'(SETS - 1);

    state_t                   state_reg, state_next;
    logic [ADDR_W-1:0]        cnt_reg, cnt_next;
    logic                     resp_valid_reg, resp_valid_next;
    logic                     fwd_hit_reg, fwd_hit_next;
    logic [WAYS-1:0]          fwd_mask_reg, fwd_mask_next;
    logic [WAYS*DATA_W-1:0]   fwd_data_reg, fwd_data_next;
    logic [WAYS*DATA_W-1:0]   init_word;

    // Per-way init pattern and per-way response mux (forwarded write data wins over array data).
    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            assign init_word[gi*DATA_W +: DATA_W] = INIT_VAL;
            assign resp_data[gi*DATA_W +: DATA_W] = (fwd_hit_reg && fwd_mask_reg[gi])
                                                  ? fwd_data_reg[gi*DATA_W +: DATA_W]
                                                  : arr_r_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign resp_valid = resp_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_INIT;
            cnt_reg        <= '0;
            resp_valid_reg <= 1'b0;
            fwd_hit_reg    <= 1'b0;
            fwd_mask_reg   <= '0;
            fwd_data_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            resp_valid_reg <= resp_valid_next;
            fwd_hit_reg    <= fwd_hit_next;
            fwd_mask_reg   <= fwd_mask_next;
            fwd_data_reg   <= fwd_data_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        init_done       = 1'b0;
        rd_ready        = 1'b0;
        wr_ready        = 1'b0;
        arr_r_addr      = rd_set;
        arr_w_en        = 1'b0;
        arr_w_addr      = wr_set;
        arr_w_maskOH    = wr_maskOH;
        arr_w_data      = wr_data;
        resp_valid_next = 1'b0;
        fwd_hit_next    = 1'b0;
        fwd_mask_next   = wr_maskOH;
        fwd_data_next   = wr_data;

        unique case (state_reg)
            ST_INIT: begin
                arr_w_en     = 1'b1;
                arr_w_addr   = cnt_reg;
                arr_w_maskOH = '1;
                arr_w_data   = init_word;
                cnt_next     = cnt_reg + ADDR_W'(1);
                if (cnt_reg == LAST_SET) begin
                    cnt_next   = '0;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                init_done       = 1'b1;
                rd_ready        = 1'b1;
                wr_ready        = 1'b1;
                arr_w_en        = wr_valid;
                resp_valid_next = rd_valid;
                // The array's read-during-write result is never trusted; same-set hits are forwarded.
                fwd_hit_next    = rd_valid && wr_valid && (rd_set == wr_set);
                if (flush) begin
                    state_next = ST_INIT;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_INIT;
                cnt_next   = '0;
            end
        endcase
    end

endmodule
